// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared width, reset vector, address type and decoded
//               operation encoding for the program counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int             PC_WIDTH        = 8;
    localparam logic [7:0]     PC_RESET_VECTOR = 8'h00;

    typedef logic [PC_WIDTH-1:0] pc_t;

    // Decoded counter operation; LOAD has priority over INC in the decoder.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_op_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_incrementer.sv
`default_nettype none
// ============================================================================
// Module      : pc_incrementer
// Description : Combinational a+1 with carry-out. The carry marks the
//               all-ones to zero roll-over of the program counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_incrementer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // One extra bit on the adder exposes the carry-out directly.
    always_comb begin
        {carry, sum} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    end

endmodule : pc_incrementer
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Program counter for the CPU8bit core. Holds, increments by
//               one (modulo 2**WIDTH) or loads an absolute jump target.
//               Output is a pure register with asynchronous active-high reset.
//               Optional macro PC_WRAP_FLAG_EN adds the registered pc_wrap
//               pulse, high for one cycle after an increment rolls over.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump,
    input  logic             up,
    input  logic [WIDTH-1:0] in,
`ifdef PC_WRAP_FLAG_EN
    output logic             pc_wrap,
`endif
    output logic [WIDTH-1:0] PC_next
);

    pc_op_e           op;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_d;
`ifdef PC_WRAP_FLAG_EN
    logic             inc_carry;
`else
    // Carry is only meaningful for the wrap flag; without it the bit is spare.
    logic             inc_carry_unused;
`endif

    pc_incrementer #(
        .WIDTH (WIDTH)
    ) u_incrementer (
        .a     (PC_next),
        .sum   (pc_inc),
`ifdef PC_WRAP_FLAG_EN
        .carry (inc_carry)
`else
        .carry (inc_carry_unused)
`endif
    );

    // Priority decode: jump wins over up, otherwise hold.
    always_comb begin
        op = PC_HOLD;
        if (jump) begin
            op = PC_LOAD;
        end else if (up) begin
            op = PC_INC;
        end
    end

    // Next-value select for the PC register.
    always_comb begin
        pc_d = PC_next;
        case (op)
            PC_LOAD: pc_d = in;
            PC_INC:  pc_d = pc_inc;
            default: pc_d = PC_next;
        endcase
    end

    // PC register; reset takes effect immediately and discards pending ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_next <= RESET_VECTOR;
        end else begin
            PC_next <= pc_d;
        end
    end

`ifdef PC_WRAP_FLAG_EN
    // Wrap pulse: set only by an increment carrying out, never by a jump to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_wrap <= 1'b0;
        end else begin
            pc_wrap <= (op == PC_INC) && inc_carry;
        end
    end
`endif

endmodule : program_counter
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter
// Description : Directed, table-driven bench for program_counter, plus
//               hand-written sequences for asynchronous reset timing and
//               falling-edge stability. Wrap checks follow PC_WRAP_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;

    logic       clk;
    logic       rst;
    logic       jump;
    logic       up;
    logic [7:0] in_addr;
    logic [7:0] pc;
`ifdef PC_WRAP_FLAG_EN
    logic       wrap;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       jump;
        logic       up;
        logic [7:0] addr;
        logic [7:0] exp_pc;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs [0:26];

    program_counter dut (
        .clk     (clk),
        .rst     (rst),
        .jump    (jump),
        .up      (up),
        .in      (in_addr),
`ifdef PC_WRAP_FLAG_EN
        .pc_wrap (wrap),
`endif
        .PC_next (pc)
    );

    // 10-unit clock, first rising edge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_pc(input string name, input logic [7:0] exp);
        total++;
        if (pc !== exp) begin
            bad++;
            $display("FAIL %s: PC_next got %02h expected %02h at t=%0t", name, pc, exp, $time);
        end
    endtask

    task automatic check_wrap(input string name, input logic exp);
`ifdef PC_WRAP_FLAG_EN
        total++;
        if (wrap !== exp) begin
            bad++;
            $display("FAIL %s: pc_wrap got %0b expected %0b at t=%0t", name, wrap, exp, $time);
        end
`else
        if (exp === 1'bx) $display("unexpected x wrap expectation in %s", name);
`endif
    endtask

    // Drive one record at the falling edge, then check just after the rising edge.
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            jump    = vecs[i].jump;
            up      = vecs[i].up;
            in_addr = vecs[i].addr;
            @(posedge clk);
            #1;
            check_pc($sformatf("vec%0d", i), vecs[i].exp_pc);
            check_wrap($sformatf("vec%0d", i), vecs[i].exp_wrap);
        end
    endtask

    initial begin
        //            rst   jump  up    in     pc     wrap
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 1'b0}; // release, idle
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h04, 8'h04, 1'b0}; // jump
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h04, 8'h04, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h04, 1'b0}; // hold
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h04, 8'h05, 1'b0}; // count
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h04, 8'h06, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h04, 8'h07, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h20, 8'h20, 1'b0}; // jump beats up
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h33, 8'h20, 1'b0}; // in ignored
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'hFE, 8'hFE, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0}; // no carry yet
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1}; // wrap
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // pulse ends
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1}; // wrap again
        vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0}; // up held: one pulse only
        vecs[18] = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h10, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}; // jump to 0: no wrap
        vecs[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 8'h55, 8'h55, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 1'b1, 8'h77, 8'h00, 1'b0}; // reset beats jump
        vecs[23] = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[25] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0}; // reset clears wrap
        vecs[26] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};

        // Reset asserted at time zero; output must settle before any edge.
        rst     = 1'b1;
        jump    = 1'b0;
        up      = 1'b0;
        in_addr = 8'h04;
        #2;
        check_pc("reset_no_edge", 8'h00);
        check_wrap("reset_no_edge", 1'b0);

        // Idle release, jump, hold, count.
        run_vecs(0, 8);

        // Raise reset between edges while counting: cleared before next edge.
        #2;
        rst = 1'b1;
        #1;
        check_pc("async_rst_mid", 8'h00);
        // Reset held across an edge with up=1 keeps the PC at the vector.
        @(posedge clk);
        #1;
        check_pc("rst_held", 8'h00);
        // First edge after release evaluates up normally.
        @(negedge clk);
        rst = 1'b0;
        up  = 1'b1;
        @(posedge clk);
        #1;
        check_pc("rst_release_inc", 8'h01);

        // Priority, wrap-around, jump to zero, reset interactions.
        run_vecs(9, 26);

        // A jump request presented on a falling edge must not move the PC.
        @(negedge clk);
        jump    = 1'b1;
        up      = 1'b0;
        in_addr = 8'hAA;
        #1;
        check_pc("negedge_stable", 8'h00);
        @(posedge clk);
        #1;
        check_pc("negedge_then_load", 8'hAA);
        @(negedge clk);
        jump = 1'b0;
        up   = 1'b1;
        #1;
        check_pc("negedge_stable_inc", 8'hAA);
        @(posedge clk);
        #1;
        check_pc("inc_after_negedge", 8'hAB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_program_counter
`default_nettype wire
